nibble_packer: RTL

- Downstream stage of the nibble-selection block: consumes its 4-bit DATA_OUT stream, one nibble per accepted transfer.
- Packs NIBBLES_PER_WORD consecutive nibbles into one word. First nibble goes to the LSBs.
- Presents the word to the next stage on a valid/ready handshake, with a one-word output register and backpressure to the nibble source.
- FLUSH emits a zero-padded partial word.

---
 rtl/nibble_pkg.sv | 17 +
 rtl/word_out_reg.sv | 34 +++
 rtl/nibble_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared constants, state type and width helper for the nibble packer
package nibble_pkg;

    localparam int NIB_W = 4;
    localparam int DEFAULT_NIBBLES_PER_WORD = 8;

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_t;

    // Width needed to hold a nibble count in 0..n inclusive.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/word_out_reg.sv
// rtl/word_out_reg.sv - one-entry valid/ready holding register for packed words
module word_out_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [3:0]        len,
    input  logic              ready,
    output logic              valid,
    output logic [WORD_W-1:0] word,
    output logic [3:0]        word_len,
    output logic              can_load
);

    // A new word may enter when the slot is empty or is being drained this cycle.
    assign can_load = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            word     <= '0;
            word_len <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            word     <= data;
            word_len <= len;
        end else if (ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs a nibble stream into words; NIBBLE_PACKER_PARITY_EN adds WORD_PARITY
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int NIBBLES_PER_WORD = DEFAULT_NIBBLES_PER_WORD,
    parameter int WORD_W           = NIB_W * NIBBLES_PER_WORD
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        NIB_IN,
    input  logic              NIB_VALID,
    output logic              NIB_READY,
    input  logic              FLUSH,
`ifdef NIBBLE_PACKER_PARITY_EN
    output logic              WORD_PARITY,
`endif
    output logic [WORD_W-1:0] WORD_OUT,
    output logic [3:0]        WORD_LEN,
    output logic              WORD_VALID,
    input  logic              WORD_READY
);

    localparam int CNT_W = len_width(NIBBLES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES_PER_WORD - 1);

    state_t              state_q, state_nx;
    logic [WORD_W-1:0]   asm_q, asm_nx, merged;
    logic [CNT_W-1:0]    cnt_q, cnt_nx, cnt_inc;
    logic [3:0]          park_len_q, park_len_nx;
    logic                nib_acc, word_acc, close;
    logic                load, can_load;
    logic [WORD_W-1:0]   load_data;
    logic [3:0]          load_len;

    assign NIB_READY = (state_q == ST_FILL);
    assign nib_acc   = NIB_VALID && NIB_READY;
    assign word_acc  = WORD_VALID && WORD_READY;

    assign merged  = asm_q | (nib_acc ? ({{(WORD_W-NIB_W){1'b0}}, NIB_IN} << {cnt_q, 2'b00}) : '0);
    assign cnt_inc = cnt_q + CNT_W'(nib_acc);
    // A flush also closes an empty word when a nibble lands in the same cycle.
    assign close   = (nib_acc && (cnt_q == LAST_IDX)) || (FLUSH && ((cnt_q != '0) || nib_acc));

    always_comb begin
        state_nx    = state_q;
        asm_nx      = asm_q;
        cnt_nx      = cnt_q;
        park_len_nx = park_len_q;
        load        = 1'b0;
        load_data   = merged;
        load_len    = 4'(cnt_inc);
        unique case (state_q)
            ST_FILL: begin
                if (close) begin
                    asm_nx = '0;
                    cnt_nx = '0;
                    if (can_load) begin
                        load = 1'b1;
                    end else begin
                        asm_nx      = merged;
                        park_len_nx = 4'(cnt_inc);
                        state_nx    = ST_FULL;
                    end
                end else begin
                    asm_nx = merged;
                    cnt_nx = cnt_inc;
                end
            end
            ST_FULL: begin
                load_data = asm_q;
                load_len  = park_len_q;
                if (word_acc) begin
                    load     = 1'b1;
                    asm_nx   = '0;
                    state_nx = ST_FILL;
                end
            end
            default: state_nx = ST_FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_FILL;
            asm_q      <= '0;
            cnt_q      <= '0;
            park_len_q <= '0;
        end else begin
            state_q    <= state_nx;
            asm_q      <= asm_nx;
            cnt_q      <= cnt_nx;
            park_len_q <= park_len_nx;
        end
    end

    word_out_reg #(
        .WORD_W(WORD_W)
    ) u_word_out_reg (
        .clk      (CLK),
        .rst      (RESET),
        .load     (load),
        .data     (load_data),
        .len      (load_len),
        .ready    (WORD_READY),
        .valid    (WORD_VALID),
        .word     (WORD_OUT),
        .word_len (WORD_LEN),
        .can_load (can_load)
    );

`ifdef NIBBLE_PACKER_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^load_data;
        end
    end

    assign WORD_PARITY = parity_q;
`endif

endmodule
